muldiv_sequencer: RTL and testbench

- Sequences the shared multiply/divide resources: MULT, MULTU, DIV and DIVU.
- Accepts one HI/LO-producing op at a time from the controller and latches its operands.
- Pulses the start of the selected unit and waits for completion, then writes HI/LO in one cycle.
- Drives a stall to the controller while busy; replaces ad-hoc busy ORing in the top level.

---
 rtl/muldiv_sequencer_if.sv | 53 +++++
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Controller and mul/div unit signals seen by muldiv_sequencer.
// master = sequencer side, slave = controller plus arithmetic units.
interface muldiv_sequencer_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_ready;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        mul_start;
  logic        mulu_start;
  logic        div_start;
  logic        divu_start;
  logic        mul_done;
  logic        mulu_done;
  logic        div_busy;
  logic        divu_busy;
  logic [63:0] mul_z;
  logic [63:0] mulu_z;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] divu_q;
  logic [31:0] divu_r;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        hi_we;
  logic        lo_we;
  logic        stall;
  logic        result_valid;
  logic        err;
  logic        divz;

  modport master (
    input  op_valid, op_code, rs_val, rt_val,
    input  mul_done, mulu_done, div_busy, divu_busy,
    input  mul_z, mulu_z, div_q, div_r, divu_q, divu_r,
    output op_ready, opa, opb,
    output mul_start, mulu_start, div_start, divu_start,
    output hi_wdata, lo_wdata, hi_we, lo_we,
    output stall, result_valid, err, divz
  );

  modport slave (
    output op_valid, op_code, rs_val, rt_val,
    output mul_done, mulu_done, div_busy, divu_busy,
    output mul_z, mulu_z, div_q, div_r, divu_q, divu_r,
    input  op_ready, opa, opb,
    input  mul_start, mulu_start, div_start, divu_start,
    input  hi_wdata, lo_wdata, hi_we, lo_we,
    input  stall, result_valid, err, divz
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences MULT/MULTU/DIV/DIVU through the shared units and writes HI/LO.
// Optional MULDIV_DIVZERO_EN: DIV/DIVU by zero bypasses the divider and pulses divz.
//
// state  | meaning
// IDLE   | ready for an op; accept latches operands and opcode
// LAUNCH | one-cycle start pulse to the selected unit, counter cleared
// WAIT   | count cycles, watch the unit's completion indicator
// WB     | one-cycle HI/LO write and result_valid
// ABORT  | one-cycle err for illegal op or timeout
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic                clk,
  input logic                rstn,
  muldiv_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB, S_ABORT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      opa_q, opb_q, hi_q, lo_q;
  logic [63:0]      res_sel;
  logic             accept, unit_done, complete, at_tc, dz_in;

  assign accept   = (state_q == S_IDLE) & bus.op_valid;
  // first WAIT cycle is skipped so a level left over from the previous op is never taken
  assign complete = (cnt_q != '0) & unit_done;
  assign at_tc    = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MULDIV_DIVZERO_EN
  logic dz_q;

  assign dz_in    = ~bus.op_code[2] & bus.op_code[1] & (bus.rt_val == 32'd0);
  assign bus.divz = (state_q == S_WB) & dz_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dz_q <= 1'b0;
    else if (accept) dz_q <= dz_in;
  end
`else
  assign dz_in    = 1'b0;
  assign bus.divz = 1'b0;
`endif

  always_comb begin
    unit_done = 1'b0;
    res_sel   = '0;
    case (op_q)
      2'd0: begin unit_done = bus.mul_done;   res_sel = bus.mul_z;                end
      2'd1: begin unit_done = bus.mulu_done;  res_sel = bus.mulu_z;               end
      2'd2: begin unit_done = ~bus.div_busy;  res_sel = {bus.div_r, bus.div_q};   end
      default: begin unit_done = ~bus.divu_busy; res_sel = {bus.divu_r, bus.divu_q}; end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q <= bus.rs_val;
        opb_q <= bus.rt_val;
        op_q  <= bus.op_code[1:0];
      end
      if (state_q == S_LAUNCH) cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if ((state_q == S_WAIT) && complete) begin
        hi_q <= res_sel[63:32];
        lo_q <= res_sel[31:0];
      end else if (accept && dz_in) begin
        hi_q <= bus.rs_val;
        lo_q <= '1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.op_ready     = 1'b0;
    bus.stall        = 1'b1;
    bus.mul_start    = 1'b0;
    bus.mulu_start   = 1'b0;
    bus.div_start    = 1'b0;
    bus.divu_start   = 1'b0;
    bus.hi_we        = 1'b0;
    bus.lo_we        = 1'b0;
    bus.result_valid = 1'b0;
    bus.err          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        bus.stall    = bus.op_valid;
        if (bus.op_valid) begin
          if (bus.op_code[2]) state_d = S_ABORT;
          else if (dz_in)     state_d = S_WB;
          else                state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        case (op_q)
          2'd0:    bus.mul_start  = 1'b1;
          2'd1:    bus.mulu_start = 1'b1;
          2'd2:    bus.div_start  = 1'b1;
          default: bus.divu_start = 1'b1;
        endcase
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (complete)   state_d = S_WB;
        else if (at_tc) state_d = S_ABORT;
      end
      S_WB: begin
        bus.hi_we        = 1'b1;
        bus.lo_we        = 1'b1;
        bus.result_valid = 1'b1;
        state_d          = S_IDLE;
      end
      S_ABORT: begin
        bus.err = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.opa      = opa_q;
  assign bus.opb      = opb_q;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: behavioural unit models plus a
// reference model predicting writeback cycle, HI/LO values, starts and err.
module tb_muldiv_sequencer;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // unit models: each unit finishes lat[u] cycles after seeing its start
  logic [31:0] ua = '0, ub = '0;
  int lat[4];
  int ucnt[4];
  logic [3:0] starts;
  assign starts = {bus.divu_start, bus.div_start, bus.mulu_start, bus.mul_start};

  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (starts[u]) ucnt[u] <= lat[u];
      else if (ucnt[u] > 0) ucnt[u] <= ucnt[u] - 1;
    end
  end

  assign bus.mul_done  = (ucnt[0] == 0);
  assign bus.mulu_done = (ucnt[1] == 0);
  assign bus.div_busy  = (ucnt[2] != 0);
  assign bus.divu_busy = (ucnt[3] != 0);
  assign bus.mul_z  = $signed({{32{ua[31]}}, ua}) * $signed({{32{ub[31]}}, ub});
  assign bus.mulu_z = {32'd0, ua} * {32'd0, ub};

  always_comb begin
    int sa, sb;
    sa = ua;
    sb = ub;
    bus.div_q = 32'hFFFF_FFFF;  bus.div_r = ua;
    bus.divu_q = 32'hFFFF_FFFF; bus.divu_r = ua;
    if (ub != 0) begin
      bus.div_q  = sa / sb;
      bus.div_r  = sa % sb;
      bus.divu_q = ua / ub;
      bus.divu_r = ua % ub;
    end
  end

  typedef struct {
    int          idx;
    bit          is_err;
    int          start;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          divz;
  } exp_t;

  logic [31:0] prev_hi = '0, prev_lo = '0;

  // idx = cycles after the accept edge at which the WB/ABORT cycle appears
  function automatic exp_t model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                                 input int n, input logic [31:0] hi0, input logic [31:0] lo0);
    exp_t e;
    longint p;
    longint unsigned pu;
    int sa, sb;
    sa = a;
    sb = b;
    e.hi = hi0; e.lo = lo0; e.divz = 0; e.start = -1; e.is_err = 0; e.idx = 0;
    if (code[2]) begin
      e.is_err = 1;
      return e;
    end
`ifdef MULDIV_DIVZERO_EN
    if (code[1] && b == 0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.divz = 1;
      return e;
    end
`endif
    e.start = int'(code);
    if (n + 1 > TMO) begin
      e.is_err = 1;
      e.idx = TMO + 1;
      return e;
    end
    e.idx = 2 + n;
    case (code[1:0])
      2'd0: begin p = longint'(sa) * longint'(sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin pu = a; pu = pu * b; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      2'd2: begin
        if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
        else begin e.hi = sa % sb; e.lo = sa / sb; end
      end
      default: begin
        if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
    endcase
    return e;
  endfunction

  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int n);
    exp_t e;
    int idx, sc[4];
    bit seen, busy_ok;
    e = model(code, a, b, n, prev_hi, prev_lo);
    @(negedge clk);
    ua = a; ub = b;
    lat[code[1:0]] = n;
    bus.op_valid = 1'b1; bus.op_code = code; bus.rs_val = a; bus.rt_val = b;
    #1;
    chk("ready_acc", bus.op_ready, 1);
    chk("stall_acc", bus.stall, 1);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
    chk("opa", bus.opa, a);
    chk("opb", bus.opb, b);
    idx = 0; seen = 0; busy_ok = 1;
    for (int u = 0; u < 4; u++) sc[u] = 0;
    while (!seen && idx < 200) begin
      for (int u = 0; u < 4; u++) if (starts[u]) sc[u]++;
      if (bus.result_valid || bus.err) seen = 1;
      else begin
        if (!bus.stall || bus.op_ready || bus.hi_we || bus.lo_we) busy_ok = 0;
        idx++;
        @(negedge clk);
      end
    end
    if (!seen) chk("op_finish_bound", 0, 1);
    else begin
      chk("busy_outputs", busy_ok, 1);
      chk("term_cycle", idx, e.idx);
      chk("err", bus.err, e.is_err);
      chk("we", {bus.hi_we, bus.lo_we, bus.result_valid}, e.is_err ? 3'b000 : 3'b111);
      chk("hi", bus.hi_wdata, e.hi);
      chk("lo", bus.lo_wdata, e.lo);
      chk("divz", bus.divz, e.divz);
      chk("stall_term", bus.stall, 1);
      for (int u = 0; u < 4; u++) chk($sformatf("starts%0d", u), sc[u], (e.start == u) ? 1 : 0);
      @(negedge clk);
      chk("ready_after", bus.op_ready, 1);
      chk("pulses_after", {bus.hi_we, bus.lo_we, bus.result_valid, bus.err, bus.divz}, 0);
      chk("hold", {bus.hi_wdata, bus.lo_wdata}, {e.hi, e.lo});
    end
    prev_hi = e.hi;
    prev_lo = e.lo;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ops"}, {bus.opa, bus.opb}, 0);
    chk({tag, "_res"}, {bus.hi_wdata, bus.lo_wdata}, 0);
    chk({tag, "_ctl"}, {starts, bus.hi_we, bus.lo_we, bus.result_valid, bus.err, bus.divz,
                        bus.stall, bus.op_ready}, 11'b000_0000_0001);
  endtask

  initial begin
    logic [2:0] code;
    logic [31:0] a, b;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.rs_val = '0; bus.rt_val = '0;
    for (int u = 0; u < 4; u++) lat[u] = 1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_init");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_stall", bus.stall, 0);

    do_op(3'b000, 32'hFFFF_FFFE, 32'd3, 3);
    do_op(3'b011, 32'd100, 32'd7, 5);
    do_op(3'b101, 32'h1234_5678, 32'h9, 2);
    do_op(3'b010, 32'hDEAD_BEEF, 32'd17, 1000);
    do_op(3'b010, 32'hFFFF_FF00, 32'd9, TMO - 1);
    do_op(3'b001, 32'h8000_0001, 32'hFFFF_FFFF, TMO);
    do_op(3'b001, 32'hCAFE_0001, 32'h0000_F00D, 1);

    // reset in the middle of a MULTU
    @(negedge clk);
    ua = 32'h7777_0000; ub = 32'h3;
    lat[1] = 10;
    bus.op_valid = 1'b1; bus.op_code = 3'b001; bus.rs_val = ua; bus.rt_val = ub;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    rstn = 1'b1;
    do_op(3'b000, 32'h0001_0000, 32'hFFFF_FFF0, 2);

    do_op(3'b010, 32'd5, 32'd0, 2);
    do_op(3'b011, 32'hFFFF_FFFF, 32'd0, 3);

    for (int k = 0; k < 40; k++) begin
      code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (code == 3'b010 && b == 32'hFFFF_FFFF) b = 32'd1;
      do_op(code, a, b, $urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
